// File: rtl/uart_pkg.sv
// Shared UART scheduler types, widths and the round-robin search helper.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_SEND  = 2'd1,
        SCHED_STALL = 2'd2
    } sched_state_e;

    // Index of the first set request at or after ptr (wrapping over n entries), -1 if none.
    function automatic int rr_first(input logic [7:0] req, input int ptr, input int n);
        int win;
        int idx;
        win = -1;
        for (int i = 7; i >= 0; i--) begin
            if (i < n) begin
                idx = (ptr + i) % n;
                if (req[idx]) win = idx;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: request vector and start pointer in, one-hot grant out.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    int win;

    always_comb begin
        win = rr_first(8'(req), int'(ptr), N);
        gnt = '0;
        for (int i = 0; i < N; i++) gnt[i] = (win == i);
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin message scheduler sharing one uart_tx among NUM_REQ requesters.
// Optional stall timeout/abort enabled by defining UART_SCHED_TIMEOUT_EN.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = UART_DATA_W,
    parameter int TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        grant,
    input  logic                      tx_load,
    output logic                      tx_en,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      busy
`ifdef UART_SCHED_TIMEOUT_EN
    ,
    output logic [NUM_REQ-1:0]        timeout_err
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    sched_state_e       state, state_nxt;
    logic [PTR_W-1:0]   rr, win, arb_idx, sel;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [2:0]         sync;
    logic               load_p;
    logic               last_q;
    logic               capture, rel_msg, msg_done;
    logic [DATA_W-1:0]  cap_byte;
    logic               cap_last;

    rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_arb (
        .req (req_valid),
        .ptr (rr),
        .gnt (arb_gnt)
    );

    // tx_load is asynchronous: two sync flops, then sync[2] as the edge-detect history.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= '0;
            load_p <= 1'b0;
        end else begin
            sync   <= {sync[1:0], tx_load};
            load_p <= sync[1] & ~sync[2];
        end
    end

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (arb_gnt[i]) arb_idx = PTR_W'(i);
    end

    // In IDLE the arbiter picks the source; afterwards only the owner is looked at.
    assign sel = (state == SCHED_IDLE) ? arb_idx : win;

    always_comb begin
        cap_byte = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (sel == PTR_W'(i)) cap_byte = req_data[i*DATA_W +: DATA_W];
        cap_last = req_last[sel];
    end

`ifdef UART_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT+1);
    logic [CNT_W-1:0] stall_cnt;
    logic             abort;
`endif

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        rel_msg   = 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
        abort     = 1'b0;
`endif
        tx_en     = (state == SCHED_SEND);
        busy      = (state != SCHED_IDLE);
        case (state)
            SCHED_IDLE: begin
                if (|req_valid) begin
                    capture   = 1'b1;
                    state_nxt = SCHED_SEND;
                end
            end
            SCHED_SEND: begin
                if (load_p) begin
                    if (last_q) begin
                        rel_msg   = 1'b1;
                        state_nxt = SCHED_IDLE;
                    end else if (req_valid[win]) begin
                        capture = 1'b1;
                    end else begin
                        state_nxt = SCHED_STALL;
                    end
                end
            end
            SCHED_STALL: begin
                if (req_valid[win]) begin
                    capture   = 1'b1;
                    state_nxt = SCHED_SEND;
                end
`ifdef UART_SCHED_TIMEOUT_EN
                else if (stall_cnt == CNT_W'(TIMEOUT-1)) begin
                    abort     = 1'b1;
                    state_nxt = SCHED_IDLE;
                end
`endif
            end
            default: state_nxt = SCHED_IDLE;
        endcase
    end

`ifdef UART_SCHED_TIMEOUT_EN
    assign msg_done = rel_msg | abort;
`else
    assign msg_done = rel_msg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SCHED_IDLE;
            grant   <= '0;
            win     <= '0;
            rr      <= '0;
            tx_data <= '0;
            last_q  <= 1'b0;
            req_ack <= '0;
        end else begin
            state   <= state_nxt;
            req_ack <= '0;
            if (capture) begin
                tx_data      <= cap_byte;
                last_q       <= cap_last;
                req_ack[sel] <= 1'b1;
                if (state == SCHED_IDLE) begin
                    grant <= arb_gnt;
                    win   <= arb_idx;
                end
            end
            if (msg_done) begin
                grant <= '0;
                rr    <= (win == PTR_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
            end
        end
    end

`ifdef UART_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt   <= '0;
            timeout_err <= '0;
        end else begin
            stall_cnt   <= (state == SCHED_STALL && state_nxt == SCHED_STALL) ? stall_cnt + 1'b1 : '0;
            timeout_err <= '0;
            if (abort) timeout_err[win] <= 1'b1;
        end
    end
`endif

endmodule
